// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe: three-stage unsigned WIDTH x WIDTH Urdhva Tiryakbhyam multiplier
// with valid/ready handshake on both sides and a combinational stall chain.
//   stage 1: four H x H quadrant products (LL, LH, HL, HH)
//   stage 2: LL, HH and MID = LH + HL (carry kept)
//   stage 3: p = LL + (MID << H) + (HH << WIDTH)
// Optional sideband tag travels with the data when VEDIC_MUL_TAG_EN is defined.
module vedic_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
`ifdef VEDIC_MUL_TAG_EN
  ,
  input  logic [TAG_W-1:0]     tag_in,
  output logic [TAG_W-1:0]     tag_out
`endif
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  // Elaboration-time guard on the parameter set.
  if ((WIDTH % 2) != 0 || WIDTH < 4 || TAG_W < 1) begin : g_bad_param
    $error("vedic_mul_pipe: WIDTH must be even and >= 4, TAG_W >= 1");
  end

  // H x H unsigned quadrant product, zero-extended before multiplying so the
  // result keeps all 2H bits.
  function automatic logic [2*H-1:0] mul_half(input logic [H-1:0] x,
                                               input logic [H-1:0] y);
    logic [2*H-1:0] xe;
    logic [2*H-1:0] ye;
    xe = {{H{1'b0}}, x};
    ye = {{H{1'b0}}, y};
    return xe * ye;
  endfunction

  // Cross-term sum; the extra MSB holds the carry.
  function automatic logic [2*H:0] add_mid(input logic [2*H-1:0] lh,
                                           input logic [2*H-1:0] hl);
    return {1'b0, lh} + {1'b0, hl};
  endfunction

  // Final recombination. The true product fits in PW bits, so dropping any
  // carry out of the PW-bit sum loses nothing.
  function automatic logic [PW-1:0] assemble(input logic [2*H-1:0] ll,
                                             input logic [2*H:0]   mid,
                                             input logic [2*H-1:0] hh);
    logic [PW-1:0] ll_x;
    logic [PW-1:0] mid_x;
    logic [PW-1:0] hh_x;
    ll_x  = {{(PW-2*H){1'b0}}, ll};
    mid_x = {{(PW-2*H-1){1'b0}}, mid} << H;
    hh_x  = {hh, {(PW-2*H){1'b0}}};
    return ll_x + mid_x + hh_x;
  endfunction

  logic [H-1:0] a_hi, a_lo, b_hi, b_lo;
  assign a_hi = a[WIDTH-1:H];
  assign a_lo = a[H-1:0];
  assign b_hi = b[WIDTH-1:H];
  assign b_lo = b[H-1:0];

  // Stage registers.
  logic            vld_p1_q, vld_p1_d;
  logic [2*H-1:0]  ll_p1_q, ll_p1_d, lh_p1_q, lh_p1_d;
  logic [2*H-1:0]  hl_p1_q, hl_p1_d, hh_p1_q, hh_p1_d;
  logic            vld_p2_q, vld_p2_d;
  logic [2*H-1:0]  ll_p2_q, ll_p2_d, hh_p2_q, hh_p2_d;
  logic [2*H:0]    mid_p2_q, mid_p2_d;
  logic            vld_p3_q, vld_p3_d;
  logic [PW-1:0]   p_p3_q, p_p3_d;

  // Stall chain: a stage may load when it is empty or its consumer moves.
  logic rdy_p1, rdy_p2, rdy_p3;
  // Data enables additionally require valid upstream data, so operands
  // presented with in_valid low never reach the data registers.
  logic en_p1, en_p2, en_p3;

  assign rdy_p3 = ~vld_p3_q | out_ready;
  assign rdy_p2 = ~vld_p2_q | rdy_p3;
  assign rdy_p1 = ~vld_p1_q | rdy_p2;
  assign en_p1  = rdy_p1 & in_valid;
  assign en_p2  = rdy_p2 & vld_p1_q;
  assign en_p3  = rdy_p3 & vld_p2_q;

  assign in_ready  = rdy_p1;
  assign out_valid = vld_p3_q;
  assign p         = p_p3_q;
  assign busy      = vld_p1_q | vld_p2_q | vld_p3_q;

  // Next-state for all three stages; each stage holds when its enable is low.
  always_comb begin
    vld_p1_d = vld_p1_q;
    ll_p1_d  = ll_p1_q;
    lh_p1_d  = lh_p1_q;
    hl_p1_d  = hl_p1_q;
    hh_p1_d  = hh_p1_q;
    vld_p2_d = vld_p2_q;
    ll_p2_d  = ll_p2_q;
    hh_p2_d  = hh_p2_q;
    mid_p2_d = mid_p2_q;
    vld_p3_d = vld_p3_q;
    p_p3_d   = p_p3_q;

    // stage 1: quadrant products
    if (rdy_p1) vld_p1_d = in_valid;
    if (en_p1) begin
      ll_p1_d = mul_half(a_lo, b_lo);
      lh_p1_d = mul_half(a_lo, b_hi);
      hl_p1_d = mul_half(a_hi, b_lo);
      hh_p1_d = mul_half(a_hi, b_hi);
    end

    // stage 2: cross-term sum
    if (rdy_p2) vld_p2_d = vld_p1_q;
    if (en_p2) begin
      ll_p2_d  = ll_p1_q;
      hh_p2_d  = hh_p1_q;
      mid_p2_d = add_mid(lh_p1_q, hl_p1_q);
    end

    // stage 3: recombination
    if (rdy_p3) vld_p3_d = vld_p2_q;
    if (en_p3) p_p3_d = assemble(ll_p2_q, mid_p2_q, hh_p2_q);
  end

  // Pipeline state; reset clears valids and data so nothing stale survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      ll_p1_q  <= '0;
      lh_p1_q  <= '0;
      hl_p1_q  <= '0;
      hh_p1_q  <= '0;
      vld_p2_q <= 1'b0;
      ll_p2_q  <= '0;
      hh_p2_q  <= '0;
      mid_p2_q <= '0;
      vld_p3_q <= 1'b0;
      p_p3_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      ll_p1_q  <= ll_p1_d;
      lh_p1_q  <= lh_p1_d;
      hl_p1_q  <= hl_p1_d;
      hh_p1_q  <= hh_p1_d;
      vld_p2_q <= vld_p2_d;
      ll_p2_q  <= ll_p2_d;
      hh_p2_q  <= hh_p2_d;
      mid_p2_q <= mid_p2_d;
      vld_p3_q <= vld_p3_d;
      p_p3_q   <= p_p3_d;
    end
  end

`ifdef VEDIC_MUL_TAG_EN
  logic [TAG_W-1:0] tag_p1_q, tag_p1_d;
  logic [TAG_W-1:0] tag_p2_q, tag_p2_d;
  logic [TAG_W-1:0] tag_p3_q, tag_p3_d;

  assign tag_out = tag_p3_q;

  // Tag follows the data through the same load enables.
  always_comb begin
    tag_p1_d = tag_p1_q;
    tag_p2_d = tag_p2_q;
    tag_p3_d = tag_p3_q;
    if (en_p1) tag_p1_d = tag_in;
    if (en_p2) tag_p2_d = tag_p1_q;
    if (en_p3) tag_p3_d = tag_p2_q;
  end

  // Tag registers, cleared with the rest of the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_p1_q <= '0;
      tag_p2_q <= '0;
      tag_p3_q <= '0;
    end else begin
      tag_p1_q <= tag_p1_d;
      tag_p2_q <= tag_p2_d;
      tag_p3_q <= tag_p3_d;
    end
  end
`endif

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed testbench for vedic_mul_pipe (WIDTH=8). Build with +define+VEDIC_MUL_TAG_EN
// to include the tag scenario.
module tb_vedic_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;
`ifdef VEDIC_MUL_TAG_EN
  logic [3:0]  tag_in;
  logic [3:0]  tag_out;
`endif

  int checks = 0;
  int errors = 0;

  vedic_mul_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
`ifdef VEDIC_MUL_TAG_EN
    ,
    .tag_in    (tag_in),
    .tag_out   (tag_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
`ifdef VEDIC_MUL_TAG_EN
    tag_in = 4'h0;
`endif
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++; if (p !== 16'h0000) begin errors++; $display("FAIL rst_p got %h want 0000", p); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; a = 8'd13; b = 8'd11; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0; a = 8'h5A; b = 8'hC3;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_lat1 got ov=%0b busy=%0b want ov=0 busy=1", out_valid, busy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat2 got ov=%0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || p !== 16'h008F) begin errors++; $display("FAIL single_out got ov=%0b p=%h want ov=1 p=008F", out_valid, p); end
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%0b ov=%0b want 0 0", busy, out_valid); end
    checks++; if (p !== 16'h008F) begin errors++; $display("FAIL single_p_hold got %h want 008F", p); end
  endtask

  task automatic test_corners();
    logic [7:0]  ca [3] = '{8'hFF, 8'h00, 8'h80};
    logic [7:0]  cb [3] = '{8'hFF, 8'hA5, 8'h02};
    logic [15:0] cp [3] = '{16'hFE01, 16'h0000, 16'h0100};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin in_valid = 1'b1; a = ca[c]; b = cb[c]; end
      else       begin in_valid = 1'b0; a = 8'h77; b = 8'h33; end
      #1;
      if (c >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || p !== cp[c-3]) begin
          errors++; $display("FAIL corner_%0d got ov=%0b p=%h want ov=1 p=%h", c-3, out_valid, p, cp[c-3]);
        end
      end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL corner_drain got busy=%0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ep [8] = '{16'd2, 16'd6, 16'd12, 16'd20, 16'd30, 16'd42, 16'd56, 16'd72};
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin in_valid = 1'b1; a = 8'(c + 1); b = 8'(c + 2); end
      else       in_valid = 1'b0;
      #1;
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d got %0b want 1", c, in_ready); end
      end
      if (c >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || p !== ep[c-3]) begin
          errors++; $display("FAIL b2b_out_%0d got ov=%0b p=%0d want ov=1 p=%0d", c-3, out_valid, p, ep[c-3]);
        end
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra got ov=%0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  ba [4] = '{8'd3, 8'd7, 8'd10, 8'd12};
    logic [7:0]  bb [4] = '{8'd5, 8'd9, 8'd10, 8'd12};
    logic [15:0] bp [4] = '{16'd15, 16'd63, 16'd100, 16'd144};
    int sent = 0;
    int got  = 0;
    logic acc, emit;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (cyc >= 6);
      if (sent < 4) begin in_valid = 1'b1; a = ba[sent]; b = bb[sent]; end
      else          in_valid = 1'b0;
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || p !== 16'd15) begin
          errors++; $display("FAIL bp_stall_%0d got rdy=%0b ov=%0b p=%0d want 0 1 15", cyc, in_ready, out_valid, p);
        end
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        checks++;
        if (p !== bp[got]) begin errors++; $display("FAIL bp_out_%0d got %0d want %0d", got, p, bp[got]); end
        got++;
      end
      if (acc) sent++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (got !== 4 || sent !== 4) begin errors++; $display("FAIL bp_count got sent=%0d got=%0d want 4 4", sent, got); end
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_dup got ov=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_midstream();
    logic seen;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a = 8'(20 + c); b = 8'(30 + c);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full got busy=%0b ov=%0b rdy=%0b want 1 1 0", busy, out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || p !== 16'h0000) begin
      errors++; $display("FAIL mid_async got ov=%0b busy=%0b p=%h want 0 0 0000", out_valid, busy, p);
    end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %0b want 1", in_ready); end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || p !== 16'h0000) begin errors++; $display("FAIL mid_stale got seen=%0b p=%h want 0 0000", seen, p); end
  endtask

`ifdef VEDIC_MUL_TAG_EN
  task automatic test_tag();
    logic [7:0]  ta [2] = '{8'd13, 8'd255};
    logic [7:0]  tb [2] = '{8'd11, 8'd255};
    logic [3:0]  tt [2] = '{4'h3, 4'hC};
    logic [15:0] tp [2] = '{16'h008F, 16'hFE01};
    int sent = 0;
    int got  = 0;
    logic acc, emit;
    for (int cyc = 0; cyc < 60 && got < 2; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 2) begin in_valid = 1'b1; a = ta[sent]; b = tb[sent]; tag_in = tt[sent]; end
      else          begin in_valid = 1'b0; tag_in = 4'hF; end
      #1;
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        checks++;
        if (p !== tp[got] || tag_out !== tt[got]) begin
          errors++; $display("FAIL tag_out_%0d got p=%h tag=%h want p=%h tag=%h", got, p, tag_out, tp[got], tt[got]);
        end
        got++;
      end
      if (acc) sent++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (got !== 2) begin errors++; $display("FAIL tag_count got %0d want 2", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
`ifdef VEDIC_MUL_TAG_EN
    test_tag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
